// File: rtl/proc_ctrl_pkg.sv
// Shared types and encodings for the Mary/Shelley multicycle control unit:
// FSM states, instruction classes, opcode constants, mux encodings and the
// bundle of datapath control signals.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU_REG = 4'd0,
    CL_ALU_IMM = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_MOVE    = 4'd4,
    CL_BR      = 4'd5,
    CL_BOV     = 4'd6,
    CL_JAL     = 4'd7,
    CL_RET     = 4'd8,
    CL_CLV     = 4'd9,
    CL_HALT    = 4'd10,
    CL_ILLEGAL = 4'd11
  } iclass_t;

  // Opcode groups (upper bits) and full opcodes
  localparam logic [2:0] OPG_ALU_REG = 3'b000;
  localparam logic [2:0] OPG_ALU_IMM = 3'b001;
  localparam logic [4:0] OPG_LOAD    = 5'b01000;
  localparam logic [3:0] OPG_STORE   = 4'b0101;
  localparam logic [4:0] OPG_MOVE    = 5'b01100;
  localparam logic [5:0] OP_BR       = 6'b100000;
  localparam logic [5:0] OP_BOV      = 6'b100001;
  localparam logic [5:0] OP_JAL      = 6'b100010;
  localparam logic [5:0] OP_RET      = 6'b100011;
  localparam logic [5:0] OP_CLV      = 6'b100100;
  localparam logic [5:0] OP_HALT     = 6'b111111;

  // Mux encodings
  localparam logic [2:0] PC_INC       = 3'd0;
  localparam logic [2:0] PC_BR        = 3'd1;
  localparam logic [2:0] PC_IMM       = 3'd2;
  localparam logic [2:0] PC_RA        = 3'd3;
  localparam logic [2:0] MDST_PC      = 3'd0;
  localparam logic [2:0] MDST_SP      = 3'd1;
  localparam logic [2:0] MDST_SPIMM   = 3'd2;
  localparam logic [1:0] SRCB_SHELLEY = 2'd0;
  localparam logic [1:0] SRCB_ZEXT    = 2'd1;
  localparam logic [1:0] SRC_COMP     = 2'd1;
  localparam logic [1:0] SRC_MEM      = 2'd2;

  typedef struct packed {
    logic       mem_write;
    logic       pc_write;
    logic       sp_write;
    logic       inst_write;
    logic       mary_write;
    logic       shelley_write;
    logic       comp_write;
    logic       ra_write;
    logic       ra_src;
    logic       src_a;
    logic [1:0] mem_src;
    logic [1:0] mary_src;
    logic [1:0] shelley_src;
    logic [1:0] src_b;
    logic [2:0] mem_dst;
    logic [2:0] pc_src;
    logic [2:0] sp_src;
    logic [3:0] alu_op;
  } ctrl_t;

  // Controls for the FETCH cycle: load IR from memory at PC and bump PC
  function automatic ctrl_t fetch_ctrl();
    ctrl_t c;
    c            = '0;
    c.inst_write = 1'b1;
    c.pc_write   = 1'b1;
    c.pc_src     = PC_INC;
    c.mem_dst    = MDST_PC;
    return c;
  endfunction

endpackage

// File: rtl/proc_decode.sv
// Combinational opcode decoder: instruction class, the dd/ss operand field
// and a legal bit. Unused dd values of LOAD/MOVE decode as illegal.
module proc_decode
  import proc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output iclass_t    iclass_o,
  output logic [1:0] field_o,
  output logic       legal_o
);

  // Classify the opcode; anything not matched stays illegal
  always_comb begin
    iclass_o = CL_ILLEGAL;
    field_o  = opcode_i[1:0];
    if (opcode_i[5:3] == OPG_ALU_REG) begin
      iclass_o = CL_ALU_REG;
    end else if (opcode_i[5:3] == OPG_ALU_IMM) begin
      iclass_o = CL_ALU_IMM;
    end else if (opcode_i[5:1] == OPG_LOAD) begin
      iclass_o = CL_LOAD;
    end else if (opcode_i[5:2] == OPG_STORE) begin
      iclass_o = CL_STORE;
    end else if (opcode_i[5:1] == OPG_MOVE) begin
      iclass_o = CL_MOVE;
    end else begin
      case (opcode_i)
        OP_BR:   iclass_o = CL_BR;
        OP_BOV:  iclass_o = CL_BOV;
        OP_JAL:  iclass_o = CL_JAL;
        OP_RET:  iclass_o = CL_RET;
        OP_CLV:  iclass_o = CL_CLV;
        OP_HALT: iclass_o = CL_HALT;
        default: iclass_o = CL_ILLEGAL;
      endcase
    end
    legal_o = (iclass_o != CL_ILLEGAL);
  end

endmodule

// File: rtl/processor_control.sv
// Multicycle Moore control unit for the Mary/Shelley datapath. All datapath
// controls are registered: each transition loads the outputs belonging to
// the state being entered. Also holds the sticky overflow flag, halt/illegal
// status and the retired-instruction counter.
module processor_control
  import proc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        overflow,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        SPWrite,
  output logic        InstWrite,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  MemSrc,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic [1:0]  SrcB,
  output logic [2:0]  MemDst,
  output logic [2:0]  PCSrc,
  output logic [2:0]  SPSrc,
  output logic [3:0]  AluOp,
  output logic        halted,
  output logic        illegal,
  output logic        ovf_flag,
  output logic [15:0] retired
);

  state_t      state_q;
  ctrl_t       ctrl_q;
  logic        ovf_q;
  logic        illegal_q;
  logic        halted_q;
  logic [15:0] retired_q;

  iclass_t     cls;
  logic [1:0]  field;
  logic        legal;
  logic        unused_operand;

  // Only the opcode matters here; the operand bits belong to the datapath
  assign unused_operand = ^instruction[9:0];

  proc_decode u_decode (
    .opcode_i (instruction[15:10]),
    .iclass_o (cls),
    .field_o  (field),
    .legal_o  (legal)
  );

  // EXEC controls for a legal, non-halting instruction class
  function automatic ctrl_t exec_ctrl(input iclass_t c_cls, input logic [1:0] c_field,
                                      input logic [2:0] c_alu, input logic c_ovf);
    ctrl_t c;
    c = '0;
    case (c_cls)
      CL_ALU_REG: begin
        c.alu_op     = {1'b0, c_alu};
        c.src_b      = SRCB_SHELLEY;
        c.comp_write = 1'b1;
      end
      CL_ALU_IMM: begin
        c.alu_op     = {1'b0, c_alu};
        c.src_b      = SRCB_ZEXT;
        c.comp_write = 1'b1;
      end
      CL_LOAD: c.mem_dst = MDST_SPIMM;
      CL_STORE: begin
        c.mem_dst   = MDST_SPIMM;
        c.mem_src   = c_field;
        c.mem_write = 1'b1;
      end
      CL_MOVE: begin
        if (c_field[0]) begin
          c.shelley_src   = SRC_COMP;
          c.shelley_write = 1'b1;
        end else begin
          c.mary_src   = SRC_COMP;
          c.mary_write = 1'b1;
        end
      end
      CL_BR: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_BR;
      end
      CL_BOV: begin
        // Registered flag only; the live ALU overflow is irrelevant here
        c.pc_write = c_ovf;
        c.pc_src   = PC_BR;
      end
      CL_JAL: begin
        c.ra_src   = 1'b0;
        c.ra_write = 1'b1;
        c.pc_write = 1'b1;
        c.pc_src   = PC_IMM;
      end
      CL_RET: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_RA;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // MEM controls for the second half of a LOAD
  function automatic ctrl_t mem_ctrl(input logic to_shelley);
    ctrl_t c;
    c         = '0;
    c.mem_dst = MDST_SPIMM;
    if (to_shelley) begin
      c.shelley_src   = SRC_MEM;
      c.shelley_write = 1'b1;
    end else begin
      c.mary_src   = SRC_MEM;
      c.mary_write = 1'b1;
    end
    return c;
  endfunction

  // Control FSM with registered outputs, sticky flags and retire counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_START;
      ctrl_q    <= '0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      ctrl_q <= '0;
      case (state_q)
        ST_START: begin
          state_q <= ST_FETCH;
          ctrl_q  <= fetch_ctrl();
        end
        ST_FETCH: begin
          state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (cls == CL_HALT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (!legal) begin
            illegal_q <= 1'b1;
            if (ILLEGAL_HALTS) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              // NOPed illegal opcode retires straight out of DECODE
              state_q   <= ST_FETCH;
              ctrl_q    <= fetch_ctrl();
              retired_q <= retired_q + 16'd1;
            end
          end else begin
            state_q <= ST_EXEC;
            ctrl_q  <= exec_ctrl(cls, field, instruction[12:10], ovf_q);
          end
        end
        ST_EXEC: begin
          if (cls == CL_LOAD) begin
            state_q <= ST_MEM;
            ctrl_q  <= mem_ctrl(field[0]);
          end else begin
            state_q   <= ST_FETCH;
            ctrl_q    <= fetch_ctrl();
            retired_q <= retired_q + 16'd1;
            if (cls == CL_ALU_REG || cls == CL_ALU_IMM) begin
              ovf_q <= overflow;
            end else if (cls == CL_CLV) begin
              ovf_q <= 1'b0;
            end
          end
        end
        ST_MEM: begin
          state_q   <= ST_FETCH;
          ctrl_q    <= fetch_ctrl();
          retired_q <= retired_q + 16'd1;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_START;
        end
      endcase
    end
  end

  assign MemWrite      = ctrl_q.mem_write;
  assign PCWrite       = ctrl_q.pc_write;
  assign SPWrite       = ctrl_q.sp_write;
  assign InstWrite     = ctrl_q.inst_write;
  assign mary_write    = ctrl_q.mary_write;
  assign shelley_write = ctrl_q.shelley_write;
  assign comp_write    = ctrl_q.comp_write;
  assign ra_write      = ctrl_q.ra_write;
  assign ra_src        = ctrl_q.ra_src;
  assign SrcA          = ctrl_q.src_a;
  assign MemSrc        = ctrl_q.mem_src;
  assign mary_src      = ctrl_q.mary_src;
  assign shelley_src   = ctrl_q.shelley_src;
  assign SrcB          = ctrl_q.src_b;
  assign MemDst        = ctrl_q.mem_dst;
  assign PCSrc         = ctrl_q.pc_src;
  assign SPSrc         = ctrl_q.sp_src;
  assign AluOp         = ctrl_q.alu_op;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign ovf_flag      = ovf_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_processor_control.sv
// Scoreboard bench for processor_control: the driver walks each instruction
// cycle by cycle, pushing the per-cycle expected outputs from an
// instruction-level model; a negedge monitor pops and compares.
module tb_processor_control;

  typedef struct packed {
    logic        MemWrite, PCWrite, SPWrite, InstWrite, mary_write, shelley_write;
    logic        comp_write, ra_write, ra_src, SrcA;
    logic [1:0]  MemSrc, mary_src, shelley_src, SrcB;
    logic [2:0]  MemDst, PCSrc, SPSrc;
    logic [3:0]  AluOp;
    logic        halted, illegal, ovf_flag;
    logic [15:0] retired;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        overflow;
  logic        MemWrite, PCWrite, SPWrite, InstWrite, mary_write, shelley_write;
  logic        comp_write, ra_write, ra_src, SrcA;
  logic [1:0]  MemSrc, mary_src, shelley_src, SrcB;
  logic [2:0]  MemDst, PCSrc, SPSrc;
  logic [3:0]  AluOp;
  logic        halted, illegal, ovf_flag;
  logic [15:0] retired;

  processor_control #(.ILLEGAL_HALTS(1'b1)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .overflow(overflow),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write),
    .ra_write(ra_write), .ra_src(ra_src), .SrcA(SrcA), .MemSrc(MemSrc),
    .mary_src(mary_src), .shelley_src(shelley_src), .SrcB(SrcB), .MemDst(MemDst),
    .PCSrc(PCSrc), .SPSrc(SPSrc), .AluOp(AluOp), .halted(halted), .illegal(illegal),
    .ovf_flag(ovf_flag), .retired(retired)
  );

  always #5 clock = ~clock;

  obs_t  exp_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Architectural model state
  logic        m_ovf, m_halt, m_ill;
  logic [15:0] m_ret;

  // Monitor: one expected record per cycle, sampled mid-cycle
  initial begin
    obs_t  e, act;
    string nm;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = {MemWrite, PCWrite, SPWrite, InstWrite, mary_write, shelley_write,
               comp_write, ra_write, ra_src, SrcA, MemSrc, mary_src, shelley_src, SrcB,
               MemDst, PCSrc, SPSrc, AluOp, halted, illegal, ovf_flag, retired};
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", nm, act, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic obs_t base();
    obs_t e;
    e          = '0;
    e.halted   = m_halt;
    e.illegal  = m_ill;
    e.ovf_flag = m_ovf;
    e.retired  = m_ret;
    return e;
  endfunction

  function automatic bit model_legal(input logic [5:0] op);
    int v;
    v = int'(op);
    return (v < 16) || (v == 16) || (v == 17) || (v >= 20 && v <= 23) ||
           (v == 24) || (v == 25) || (v >= 32 && v <= 36);
  endfunction

  function automatic logic [5:0] rand_op();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return {3'b000, 3'($urandom)};
      1:       return {3'b001, 3'($urandom)};
      2:       return {5'b01000, 1'($urandom)};
      3:       return {4'b0101, 2'($urandom_range(0, 2))};
      4:       return {5'b01100, 1'($urandom)};
      default: return 6'd32 + 6'($urandom_range(0, 4));
    endcase
  endfunction

  task automatic step(input obs_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic halt_run(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      instruction = 16'($urandom);
      overflow    = 1'($urandom);
      step(base(), nm);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_ovf  = 1'b0;
    m_ret  = 16'd0;
    m_halt = 1'b0;
    m_ill  = 1'b0;
    step(base(), "reset held");
    step(base(), "reset held");
    reset = 1'b0;
    step(base(), "start");
  endtask

  // One instruction from FETCH to its last cycle; abort_mem stops a LOAD
  // before MEM so the caller can assert reset there.
  task automatic do_instr(input logic [5:0] op, input logic ovf_in, input bit abort_mem);
    obs_t e;
    int   v;
    v = int'(op);
    instruction = 16'($urandom);
    overflow    = 1'($urandom);
    e = base();
    e.InstWrite = 1'b1;
    e.PCWrite   = 1'b1;
    e.PCSrc     = 3'd0;
    e.MemDst    = 3'd0;
    step(e, "fetch");
    instruction = {op, 10'($urandom)};
    overflow    = ovf_in;
    step(base(), "decode");
    if (v == 63) begin
      m_halt = 1'b1;
      halt_run(4, "halt");
      return;
    end
    if (!model_legal(op)) begin
      m_halt = 1'b1;
      m_ill  = 1'b1;
      halt_run(4, "illegal halt");
      return;
    end
    e = base();
    if (v < 16) begin
      e.AluOp      = {1'b0, op[2:0]};
      e.SrcB       = (v < 8) ? 2'd0 : 2'd1;
      e.comp_write = 1'b1;
    end else if (v == 16 || v == 17) begin
      e.MemDst = 3'd2;
    end else if (v >= 20 && v <= 23) begin
      e.MemDst   = 3'd2;
      e.MemSrc   = 2'(v - 20);
      e.MemWrite = 1'b1;
    end else if (v == 24) begin
      e.mary_src   = 2'd1;
      e.mary_write = 1'b1;
    end else if (v == 25) begin
      e.shelley_src   = 2'd1;
      e.shelley_write = 1'b1;
    end else if (v == 32) begin
      e.PCWrite = 1'b1;
      e.PCSrc   = 3'd1;
    end else if (v == 33) begin
      e.PCWrite = m_ovf;
      e.PCSrc   = 3'd1;
    end else if (v == 34) begin
      e.ra_write = 1'b1;
      e.PCWrite  = 1'b1;
      e.PCSrc    = 3'd2;
    end else if (v == 35) begin
      e.PCWrite = 1'b1;
      e.PCSrc   = 3'd3;
    end
    step(e, $sformatf("exec op=%b", op));
    if (v == 16 || v == 17) begin
      if (abort_mem) return;
      e = base();
      e.MemDst = 3'd2;
      if (v == 17) begin
        e.shelley_src   = 2'd2;
        e.shelley_write = 1'b1;
      end else begin
        e.mary_src   = 2'd2;
        e.mary_write = 1'b1;
      end
      step(e, "mem");
    end
    if (v < 16) m_ovf = ovf_in;
    if (v == 36) m_ovf = 1'b0;
    m_ret = m_ret + 16'd1;
  endtask

  initial begin
    reset       = 1'b1;
    instruction = 16'd0;
    overflow    = 1'b0;
    @(posedge clock);
    #1;
    do_reset();
    // ALU with overflow, then BOV taken
    do_instr(6'b000010, 1'b1, 1'b0);
    do_instr(6'b100001, 1'($urandom), 1'b0);
    // CLV, then BOV not taken
    do_instr(6'b100100, 1'b1, 1'b0);
    do_instr(6'b100001, 1'b1, 1'b0);
    // LOAD into shelley
    do_instr(6'b010001, 1'b0, 1'b0);
    // Reset in the MEM cycle of a LOAD
    do_instr(6'b010000, 1'b0, 1'b1);
    do_reset();
    // Randomized legal instruction stream
    for (int i = 0; i < 250; i++) begin
      do_instr(rand_op(), 1'($urandom), 1'b0);
    end
    // Counter wrap from a preloaded value
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    m_ret = 16'hFFFE;
    do_instr(6'b011000, 1'b0, 1'b0);
    do_instr(6'b011001, 1'b0, 1'b0);
    do_instr(6'b000101, 1'b0, 1'b0);
    // Illegal opcode halts with status set
    do_instr(6'b110000, 1'b0, 1'b0);
    do_reset();
    do_instr(6'b100010, 1'b0, 1'b0);
    do_instr(6'b111111, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d records left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
